// File: rtl/pe_operand_feeder_pkg.sv
// Shared widths and FSM encoding for the PE operand feeder and its read pipe.
package pe_operand_feeder_pkg;

  localparam int WORD_WIDTH_DEF = 128;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int LEN_WIDTH_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } feed_state_e;

endpackage

// File: rtl/pe_operand_feeder_read_pipe.sv
// Return path from the global buffers: delays rd into rvalid, then registers
// the returned data onto the array operands, or zeros when no beat returned.
module gbuf_read_pipe
  import pe_operand_feeder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_i,
  input  logic [WORD_WIDTH-1:0] a_rdata_i,
  input  logic [DATA_WIDTH-1:0] b_rdata_i,
  output logic [WORD_WIDTH-1:0] a_word_o,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  valid_o
);

  logic                  rvalid_reg;
  logic                  valid_reg;
  logic [WORD_WIDTH-1:0] a_word_reg;
  logic [DATA_WIDTH-1:0] b_data_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      valid_reg  <= 1'b0;
      a_word_reg <= '0;
      b_data_reg <= '0;
    end else begin
      rvalid_reg <= rd_i;
      valid_reg  <= rvalid_reg;
      // Idle cycles present a zero product so bubbles never disturb the sum.
      a_word_reg <= rvalid_reg ? a_rdata_i : '0;
      b_data_reg <= rvalid_reg ? b_rdata_i : '0;
    end
  end

  assign a_word_o = a_word_reg;
  assign b_data_o = b_data_reg;
  assign valid_o  = valid_reg;

endmodule

// File: rtl/pe_operand_feeder.sv
// Sequences one accumulation pass: issues K paired A/B buffer reads, streams
// the returned beats into the PE array with clr on the first, then a we strobe.
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  k_len_i,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  gbuf_a_rd_o,
  output logic [ADDR_WIDTH-1:0] gbuf_a_addr_o,
  input  logic [WORD_WIDTH-1:0] gbuf_a_rdata_i,
  output logic                  gbuf_b_rd_o,
  output logic [ADDR_WIDTH-1:0] gbuf_b_addr_o,
  input  logic [DATA_WIDTH-1:0] gbuf_b_rdata_i,
  output logic [WORD_WIDTH-1:0] srca_word_o,
  output logic [DATA_WIDTH-1:0] srcb_o,
  output logic                  clr_o,
  output logic                  we_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  feed_state_e           state_reg, state_next;
  logic [LEN_WIDTH-1:0]  k_last_reg;
  logic [LEN_WIDTH-1:0]  issue_cnt_reg;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg;
  logic [ADDR_WIDTH-1:0] base_a_reg;
  logic [ADDR_WIDTH-1:0] base_b_reg;
  logic                  zero_done_reg;

  logic                  issue_rd;
  logic                  beat_valid;
  logic                  accept_start;
  logic [ADDR_WIDTH-1:0] offset;

  assign accept_start = (state_reg == ST_IDLE) && start_i;
  assign offset       = ADDR_WIDTH'(issue_cnt_reg);

  always_comb begin
    state_next  = state_reg;
    issue_rd    = 1'b0;
    busy_o      = 1'b0;
    we_o        = 1'b0;
    done_o      = zero_done_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && (k_len_i != '0)) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy_o   = 1'b1;
        issue_rd = !stall_i;
        if (!stall_i && (issue_cnt_reg == k_last_reg)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (beat_valid && (beat_cnt_reg == k_last_reg)) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy_o     = 1'b1;
        we_o       = 1'b1;
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      k_last_reg    <= '0;
      issue_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      base_a_reg    <= '0;
      base_b_reg    <= '0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // A zero-length pass completes without ever leaving IDLE.
      zero_done_reg <= accept_start && (k_len_i == '0);
      if (accept_start) begin
        issue_cnt_reg <= '0;
        beat_cnt_reg  <= '0;
        if (k_len_i != '0) begin
          k_last_reg <= k_len_i - LEN_ONE;
          base_a_reg <= base_a_i;
          base_b_reg <= base_b_i;
        end
      end else begin
        if (issue_rd) issue_cnt_reg <= issue_cnt_reg + LEN_ONE;
        if (beat_valid) beat_cnt_reg <= beat_cnt_reg + LEN_ONE;
      end
    end
  end

  // Both buffers are read in lockstep; addresses wrap naturally at ADDR_WIDTH.
  assign gbuf_a_rd_o   = issue_rd;
  assign gbuf_b_rd_o   = issue_rd;
  assign gbuf_a_addr_o = issue_rd ? (base_a_reg + offset) : '0;
  assign gbuf_b_addr_o = issue_rd ? (base_b_reg + offset) : '0;

  gbuf_read_pipe #(
    .WORD_WIDTH(WORD_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_read_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_i     (issue_rd),
    .a_rdata_i(gbuf_a_rdata_i),
    .b_rdata_i(gbuf_b_rdata_i),
    .a_word_o (srca_word_o),
    .b_data_o (srcb_o),
    .valid_o  (beat_valid)
  );

  assign clr_o = beat_valid && (beat_cnt_reg == '0);

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed plus randomized passes against a cycle-schedule model of the feeder.
module tb_pe_operand_feeder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [9:0]   k_len_i;
  logic [9:0]   base_a_i;
  logic [9:0]   base_b_i;
  logic         stall_i;
  logic         busy_o;
  logic         done_o;
  logic         gbuf_a_rd_o;
  logic [9:0]   gbuf_a_addr_o;
  logic [127:0] gbuf_a_rdata_i;
  logic         gbuf_b_rd_o;
  logic [9:0]   gbuf_b_addr_o;
  logic [7:0]   gbuf_b_rdata_i;
  logic [127:0] srca_word_o;
  logic [7:0]   srcb_o;
  logic         clr_o;
  logic         we_o;

  logic [127:0] mem_a [0:1023];
  logic [7:0]   mem_b [0:1023];
  bit           stall_pat [0:255];
  int           chk_cnt  = 0;
  int           fail_cnt = 0;
  int           cur_cyc  = 0;

  always #5 clk_i = ~clk_i;

  pe_operand_feeder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .k_len_i       (k_len_i),
    .base_a_i      (base_a_i),
    .base_b_i      (base_b_i),
    .stall_i       (stall_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .gbuf_a_rd_o   (gbuf_a_rd_o),
    .gbuf_a_addr_o (gbuf_a_addr_o),
    .gbuf_a_rdata_i(gbuf_a_rdata_i),
    .gbuf_b_rd_o   (gbuf_b_rd_o),
    .gbuf_b_addr_o (gbuf_b_addr_o),
    .gbuf_b_rdata_i(gbuf_b_rdata_i),
    .srca_word_o   (srca_word_o),
    .srcb_o        (srcb_o),
    .clr_o         (clr_o),
    .we_o          (we_o)
  );

  // Global buffer stand-ins: one-cycle registered read.
  always @(posedge clk_i) begin
    if (gbuf_a_rd_o) gbuf_a_rdata_i <= mem_a[gbuf_a_addr_o];
    if (gbuf_b_rd_o) gbuf_b_rdata_i <= mem_b[gbuf_b_addr_o];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cur_cyc, obs, exp);
    end
  endtask

  task automatic clear_stall();
    for (int i = 0; i < 256; i++) stall_pat[i] = 1'b0;
  endtask

  // Model: read j happens in the j-th unstalled cycle from 1, its beat 2 cycles
  // later, clr with beat 0, we/done one cycle after the last beat.
  task automatic run_pass(input int k, input int ba, input int bb,
                          input int restart_k, input int rst_cyc);
    int     rd_idx [256];
    int     bt_idx [256];
    int     n_rd, c, we_cyc, ncyc, j;
    longint exp_sum, obs_sum;
    for (int i = 0; i < 256; i++) begin
      rd_idx[i] = -1;
      bt_idx[i] = -1;
    end
    n_rd = 0;
    c = 1;
    exp_sum = 0;
    obs_sum = 0;
    while (n_rd < k) begin
      if (!stall_pat[c]) begin
        rd_idx[c] = n_rd;
        bt_idx[c + 2] = n_rd;
        exp_sum += longint'(mem_b[(bb + n_rd) % 1024]) * longint'(mem_a[(ba + n_rd) % 1024][7:0]);
        n_rd++;
      end
      c++;
    end
    we_cyc = (k > 0) ? c + 2 : -1;
    if (rst_cyc >= 0) ncyc = rst_cyc + 6;
    else ncyc = (k > 0) ? we_cyc + 2 : 3;

    for (int cy = 0; cy < ncyc; cy++) begin
      bit           live, e_rd, e_bt;
      logic [127:0] e_a;
      logic [7:0]   e_b;
      cur_cyc  = cy;
      rst_i    = (cy == rst_cyc);
      start_i  = (cy == 0) || (restart_k >= 0 && cy == 2);
      k_len_i  = (cy == 2 && restart_k >= 0) ? 10'(restart_k) : 10'(k);
      base_a_i = (cy == 2 && restart_k >= 0) ? 10'(ba + 7) : 10'(ba);
      base_b_i = (cy == 2 && restart_k >= 0) ? 10'(bb + 9) : 10'(bb);
      stall_i  = stall_pat[cy];
      live = (rst_cyc < 0) || (cy < rst_cyc);
      e_rd = live && rd_idx[cy] >= 0;
      e_bt = live && bt_idx[cy] >= 0;
      j    = bt_idx[cy];
      e_a  = e_bt ? mem_a[(ba + j) % 1024] : '0;
      e_b  = e_bt ? mem_b[(bb + j) % 1024] : '0;
      @(negedge clk_i);
      check("a_rd", 128'(gbuf_a_rd_o), 128'(e_rd));
      check("b_rd", 128'(gbuf_b_rd_o), 128'(e_rd));
      if (e_rd) begin
        check("a_addr", 128'(gbuf_a_addr_o), 128'((ba + rd_idx[cy]) % 1024));
        check("b_addr", 128'(gbuf_b_addr_o), 128'((bb + rd_idx[cy]) % 1024));
      end
      check("srca", srca_word_o, e_a);
      check("srcb", 128'(srcb_o), 128'(e_b));
      check("clr", 128'(clr_o), 128'(e_bt && j == 0));
      check("we", 128'(we_o), 128'(live && k > 0 && cy == we_cyc));
      check("done", 128'(done_o), 128'(live && ((k > 0) ? cy == we_cyc : cy == 1)));
      check("busy", 128'(busy_o), 128'(live && k > 0 && cy >= 1 && cy <= we_cyc));
      obs_sum += longint'(srcb_o) * longint'(srca_word_o[7:0]);
      @(posedge clk_i);
      #1;
    end
    rst_i   = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    if (rst_cyc < 0) check("dot_sum", 128'(obs_sum), 128'(exp_sum));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_b[i] = 8'($urandom_range(1, 255));
    end
    gbuf_a_rdata_i = '0;
    gbuf_b_rdata_i = '0;
    rst_i = 1'b1;
    start_i = 1'b0;
    k_len_i = '0;
    base_a_i = '0;
    base_b_i = '0;
    stall_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_rd", 128'({gbuf_a_rd_o, gbuf_b_rd_o}), 128'(0));
    check("rst_srca", srca_word_o, 128'(0));
    check("rst_srcb", 128'(srcb_o), 128'(0));
    check("rst_clr_we", 128'({clr_o, we_o}), 128'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    clear_stall();
    run_pass(4, 'h010, 'h020, -1, -1);
    stall_pat[2] = 1'b1;
    stall_pat[3] = 1'b1;
    run_pass(4, 'h010, 'h020, -1, -1);
    clear_stall();
    run_pass(0, 'h030, 'h031, -1, -1);
    run_pass(3, 'h3FE, 'h3FF, -1, -1);
    run_pass(4, 'h040, 'h050, 7, -1);
    run_pass(8, 'h100, 'h200, -1, 4);
    run_pass(5, 'h180, 'h2F0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      clear_stall();
      for (int i = 1; i < 100; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
      run_pass($urandom_range(1, 12), $urandom_range(0, 1023), $urandom_range(0, 1023), -1, -1);
    end

    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Sequencer that reads operand A words and operand B data from the input global buffers for one accumulation pass and streams them into a pe_array.
- Drives the array's srca word, srcb data, clr and we inputs with correct relative timing.
- Sits between the input global buffers and the pe_array; it is the producer end of the array's operand/control interface.
- Inserts zero-operand bubbles whenever the buffers are stalled.

Parameters:
- WORD_WIDTH, 128, width of an A word (one lane per PE).
- DATA_WIDTH, 8, width of a B operand.
- ADDR_WIDTH, 10, global buffer address width.
- LEN_WIDTH, 10, width of the pass length K.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- start_i  in  1  pass request, sampled only in IDLE.
- k_len_i  in  LEN_WIDTH  number of beats K in the pass.
- base_a_i  in  ADDR_WIDTH  first A address.
- base_b_i  in  ADDR_WIDTH  first B address.
- stall_i  in  1  buffers unavailable; suppresses read issue.
- busy_o  out  1  pass in progress.
- done_o  out  1  one-cycle pulse at pass completion.
- gbuf_a_rd_o  out  1  A read enable.
- gbuf_a_addr_o  out  ADDR_WIDTH  A read address.
- gbuf_a_rdata_i  in  WORD_WIDTH  A read data, valid 1 cycle after rd.
- gbuf_b_rd_o  out  1  B read enable.
- gbuf_b_addr_o  out  ADDR_WIDTH  B read address.
- gbuf_b_rdata_i  in  DATA_WIDTH  B read data, valid 1 cycle after rd.
- srca_word_o  out  WORD_WIDTH  A word to array.
- srcb_o  out  DATA_WIDTH  B operand to array.
- clr_o  out  1  accumulator clear, coincident with first beat.
- we_o  out  1  result capture strobe to array.

Behaviour:
- Reset: every output 0, FSM in IDLE, all counters 0. Reset asserted mid-pass aborts the pass immediately; no done_o follows.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start_i with K>0: latch K and both bases, go to ISSUE, busy_o=1 from the next cycle.
  - start_i with K=0: done_o pulses next cycle; no reads, no clr_o, no we_o.
  - start_i while not in IDLE is ignored.
- ISSUE:
  - Each cycle with stall_i=0: assert both rd enables together at addresses base+i, then increment i.
  - With stall_i=1: no read that cycle; i holds.
  - After the read for i=K-1 is issued, go to DRAIN.
- Return path:
  - rd enable is delayed 1 cycle into rvalid.
  - On rvalid, rdata is registered onto srca_word_o/srcb_o, so a beat appears at the outputs 2 cycles after its read.
  - Cycles without rvalid drive srca_word_o=0 and srcb_o=0, a zero-product bubble that is harmless to accumulation.
- clr_o = 1 exactly in the cycle the first beat (i=0) is on the outputs; 0 otherwise.
- DRAIN:
  - Counts returned beats.
  - When beat K-1 is on the outputs, go to FLUSH.
- FLUSH:
  - One cycle with we_o=1 and done_o=1, operands zero; then IDLE.
  - busy_o drops the following cycle.
- Unstalled timing (start sampled at cycle 0):
  - Reads in cycles 1..K.
  - Beats in cycles 3..K+2; clr_o in cycle 3.
  - we_o/done_o in cycle K+3; busy_o=0 in cycle K+4.
- Address arithmetic: base+i wraps modulo 2^ADDR_WIDTH; no error is raised.
- Stall:
  - Affects issue only.
  - A read issued the cycle before stall_i rises still returns and is output normally.
  - Extra bubbles do not change the final sum.

Decomposition:
- Shared package/def include:
  - WORD_WIDTH, DATA_WIDTH, ADDR_WIDTH.
  - FSM state encoding constants (IDLE=0, ISSUE=1, DRAIN=2, FLUSH=3).
- One natural sub-module: gbuf_read_pipe, containing the rd→rvalid delay and the registered data/zero-bubble mux.
- The FSM and counters stay in pe_operand_feeder.

Test Plan:
- K=4, base_a=0x010, base_b=0x020, no stall:
  - A reads at 0x010..0x013 in cycles 1–4.
  - Beats in cycles 3–6; clr_o only in cycle 3.
  - we_o and done_o in cycle 7; busy_o low in cycle 8.
- K=4, stall_i high in cycles 2–3:
  - Read of 0x011 delayed to cycle 4.
  - Output gap cycles carry zeros.
  - we_o in cycle 9; beat order unchanged.
- K=0 start: done_o at cycle 1; no rd, no clr_o, no we_o; busy_o stays 0.
- base_a=0x3FE, K=3 (ADDR_WIDTH=10): addresses 0x3FE, 0x3FF, 0x000.
- start_i reasserted during ISSUE with different k_len_i: ignored; the original K=4 pass completes unchanged.
- rst_i pulsed in cycle 4 of a K=8 pass:
  - All outputs 0 within the same cycle; no done_o.
  - A new start after reset runs a clean pass.
